mod_n_updown_counter: RTL and testbench

Parametrised modulo-N synchronous counter. It counts up or down, with enable, parallel load, a terminal-count flag, a registered wrap/carry pulse for cascading, and a one-shot mode that stops at the terminal value. It is the general counter tile for timing and sequencing blocks in the termproject datapath, and it covers the fixed small-modulus down-counters. Multiple instances can be chained through carry_out into en of the next stage.

---
 rtl/mod_n_updown_counter_pkg.sv | 20 ++
 rtl/mod_n_updown_counter_step.sv | 43 ++++
 rtl/mod_n_updown_counter.sv | 90 +++++++++
 tb/tb_mod_n_updown_counter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter tile.
// The clamp helper works at the widest legal counter width plus one bit.
package mod_n_updown_counter_pkg;

   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   localparam int CNT_MAX_WIDTH = 16;

   localparam logic [CNT_MAX_WIDTH:0] CLAMP_ONE = (CNT_MAX_WIDTH+1)'(1);

   // Out-of-range load values saturate to the top of the count range.
   function automatic logic [CNT_MAX_WIDTH:0] clamp_mod(
      input logic [CNT_MAX_WIDTH:0] value,
      input logic [CNT_MAX_WIDTH:0] modulus
   );
      return (value >= modulus) ? (modulus - CLAMP_ONE) : value;
   endfunction

endpackage

// File: rtl/mod_n_updown_counter_step.sv
// Combinational next-value and terminal detection for a modulo-N counter.
// Works at WIDTH+1 bits so MODULUS == 2**WIDTH needs no special casing.
module mod_n_step
   import mod_n_updown_counter_pkg::*;
#(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 6
) (
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] next_o,
   output logic             at_terminal_o
);

   localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] ZERO_W = '0;
   localparam logic [WIDTH:0] TOP_W  = MOD_W - ONE_W;

   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] term_ext;
   logic [WIDTH:0] next_ext;
   logic           unused_next_msb;

   always_comb begin
      cnt_ext       = {1'b0, cnt_i};
      term_ext      = (up_i == CNT_UP) ? TOP_W : ZERO_W;
      at_terminal_o = (cnt_ext == term_ext);
      next_ext      = cnt_ext;
      if (at_terminal_o) begin
         next_ext = (up_i == CNT_DN) ? TOP_W : ZERO_W;
      end else if (up_i == CNT_UP) begin
         next_ext = cnt_ext + ONE_W;
      end else begin
         next_ext = cnt_ext - ONE_W;
      end
   end

   // Results always stay below MODULUS, so the extension bit is always zero.
   assign next_o          = next_ext[WIDTH-1:0];
   assign unused_next_msb = next_ext[WIDTH];

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter tile: load, enable, one-shot stop, terminal-count
// flag and a registered wrap pulse for cascading into the next stage's en.
module mod_n_updown_counter
   import mod_n_updown_counter_pkg::*;
#(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 6,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             one_shot,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             carry_out,
   output logic             done
);

   if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH || MODULUS < 2 ||
       MODULUS > (1 << WIDTH) || RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_params
      $error("mod_n_updown_counter: illegal WIDTH/MODULUS/RST_VAL combination");
   end

   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0]         step_next;
   logic                     at_term;
   logic [CNT_MAX_WIDTH:0]   load_clamped_ext;
   logic [WIDTH-1:0]         load_clamped;
   logic [CNT_MAX_WIDTH-WIDTH:0] unused_load_msbs;

   mod_n_step #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_step (
      .cnt_i         (cnt_q),
      .up_i          (up),
      .next_o        (step_next),
      .at_terminal_o (at_term)
   );

   assign load_clamped_ext = clamp_mod((CNT_MAX_WIDTH+1)'(load_val),
                                       (CNT_MAX_WIDTH+1)'(MODULUS));
   assign load_clamped     = load_clamped_ext[WIDTH-1:0];
   assign unused_load_msbs = load_clamped_ext[CNT_MAX_WIDTH:WIDTH];

   // Priority below is load > en > hold; rst is applied in the register stage.
   always_comb begin
      cnt_d   = cnt_q;
      carry_d = 1'b0;
      done_d  = done_q;
      if (load) begin
         cnt_d  = load_clamped;
         done_d = 1'b0;
      end else if (en && !done_q) begin
         if (at_term && one_shot) begin
            done_d = 1'b1;
         end else begin
            cnt_d   = step_next;
            carry_d = at_term;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= RST_CNT;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign cnt       = cnt_q;
   assign tc        = en & at_term;
   assign carry_out = carry_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter: three instances cover moduli 6, 10
// and 8 (power-of-two); expected values are hand-computed constants.
module tb_mod_n_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Instance A: WIDTH=3, MODULUS=6
   logic       a_rst = 1'b0, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0, a_os = 1'b0;
   logic [2:0] a_lv = '0;
   logic [2:0] a_cnt;
   logic       a_tc, a_co, a_done;

   // Instance B: WIDTH=4, MODULUS=10
   logic       b_rst = 1'b0, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0, b_os = 1'b0;
   logic [3:0] b_lv = '0;
   logic [3:0] b_cnt;
   logic       b_tc, b_co, b_done;

   // Instance C: WIDTH=3, MODULUS=8
   logic       c_rst = 1'b0, c_en = 1'b0, c_up = 1'b0, c_load = 1'b0, c_os = 1'b0;
   logic [2:0] c_lv = '0;
   logic [2:0] c_cnt;
   logic       c_tc, c_co, c_done;

   mod_n_updown_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(0)) u_a (
      .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
      .load_val(a_lv), .one_shot(a_os), .cnt(a_cnt), .tc(a_tc),
      .carry_out(a_co), .done(a_done)
   );

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_b (
      .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load),
      .load_val(b_lv), .one_shot(b_os), .cnt(b_cnt), .tc(b_tc),
      .carry_out(b_co), .done(b_done)
   );

   mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .RST_VAL(0)) u_c (
      .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load),
      .load_val(c_lv), .one_shot(c_os), .cnt(c_cnt), .tc(c_tc),
      .carry_out(c_co), .done(c_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int a_exp [7] = '{5, 4, 3, 2, 1, 0, 5};
   int e;

   initial begin
      // ---------------- A: down count modulo 6 with wrap ----------------
      a_rst = 1'b1;
      tick();
      check("A rst cnt", 32'(a_cnt), 0);
      check("A rst carry", 32'(a_co), 0);
      check("A rst done", 32'(a_done), 0);
      a_rst = 1'b0; a_en = 1'b1; a_up = 1'b0; a_os = 1'b0;
      #1;
      check("A tc at 0", 32'(a_tc), 1);
      for (int i = 0; i < 7; i++) begin
         tick();
         check($sformatf("A dn cnt %0d", i), 32'(a_cnt), a_exp[i]);
         check($sformatf("A dn carry %0d", i), 32'(a_co), (i == 0 || i == 6) ? 1 : 0);
         check($sformatf("A dn tc %0d", i), 32'(a_tc), (a_exp[i] == 0) ? 1 : 0);
      end
      a_en = 1'b0;

      // ---------------- B: up count modulo 10 ----------------
      b_rst = 1'b1;
      tick();
      check("B rst cnt", 32'(b_cnt), 0);
      b_rst = 1'b0; b_en = 1'b1; b_up = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         e = (i + 1) % 10;
         check($sformatf("B up cnt %0d", i), 32'(b_cnt), e);
         check($sformatf("B up carry %0d", i), 32'(b_co), (i == 9) ? 1 : 0);
         check($sformatf("B up tc %0d", i), 32'(b_tc), (e == 9) ? 1 : 0);
      end

      // load clamp, then load overriding en
      b_en = 1'b0; b_load = 1'b1; b_lv = 4'd13;
      tick();
      check("B load clamp", 32'(b_cnt), 9);
      b_lv = 4'd4; b_en = 1'b1;
      tick();
      check("B load over en", 32'(b_cnt), 4);
      check("B load carry", 32'(b_co), 0);
      b_load = 1'b0; b_en = 1'b0;

      // one-shot run to terminal
      b_os = 1'b1; b_load = 1'b1; b_lv = 4'd7;
      tick();
      check("B os load", 32'(b_cnt), 7);
      b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
      tick();
      check("B os cnt 8", 32'(b_cnt), 8);
      check("B os done @8", 32'(b_done), 0);
      tick();
      check("B os cnt 9", 32'(b_cnt), 9);
      check("B os done @9", 32'(b_done), 0);
      check("B os tc @9", 32'(b_tc), 1);
      tick();
      check("B os hold", 32'(b_cnt), 9);
      check("B os done set", 32'(b_done), 1);
      check("B os carry", 32'(b_co), 0);
      tick();
      check("B os hold2", 32'(b_cnt), 9);
      check("B os carry2", 32'(b_co), 0);
      b_os = 1'b0;
      tick();
      check("B os off hold", 32'(b_cnt), 9);
      check("B os off done", 32'(b_done), 1);
      b_en = 1'b0; b_load = 1'b1; b_lv = 4'd2;
      tick();
      check("B reload cnt", 32'(b_cnt), 2);
      check("B reload done", 32'(b_done), 0);

      // direction reversal mid-count
      b_lv = 4'd3;
      tick();
      check("B mid load", 32'(b_cnt), 3);
      b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
      tick();
      check("B mid up", 32'(b_cnt), 4);
      b_up = 1'b0;
      tick();
      check("B mid down", 32'(b_cnt), 3);

      // wrap to set carry, then rst beats load and en
      b_en = 1'b0; b_load = 1'b1; b_lv = 4'd9;
      tick();
      b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
      tick();
      check("B wrap carry", 32'(b_co), 1);
      b_rst = 1'b1; b_load = 1'b1; b_lv = 4'd7;
      tick();
      check("B rst prio cnt", 32'(b_cnt), 0);
      check("B rst prio done", 32'(b_done), 0);
      check("B rst prio carry", 32'(b_co), 0);
      b_rst = 1'b0; b_load = 1'b0; b_en = 1'b0;

      // ---------------- C: power-of-two modulus ----------------
      c_rst = 1'b1;
      tick();
      c_rst = 1'b0; c_load = 1'b1; c_lv = 3'd6;
      tick();
      check("C load", 32'(c_cnt), 6);
      c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
      tick();
      check("C cnt 7", 32'(c_cnt), 7);
      check("C tc @7", 32'(c_tc), 1);
      tick();
      check("C wrap cnt", 32'(c_cnt), 0);
      check("C wrap carry", 32'(c_co), 1);
      check("C wrap tc", 32'(c_tc), 0);
      c_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("C idle cnt %0d", i), 32'(c_cnt), 0);
         check($sformatf("C idle tc %0d", i), 32'(c_tc), 0);
         check($sformatf("C idle carry %0d", i), 32'(c_co), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
